div_seq: RTL

//   Iterative restoring divider; the inverse companion of the sequential multiplier in the Multipy datapath.

---
 rtl/div_seq.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// div_seq: iterative restoring divider for the DIV/DIVU path.
// It produces one quotient bit per clock. The quotient goes to LO and the
// remainder goes to HI. Control is a start/busy/done handshake.
// The optional macro SIGNED_DIV_EN adds signed division selected by sgn.
// Without SIGNED_DIV_EN, sgn is ignored and every operation is unsigned.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one restoring step per cycle, r_cnt counts down to 1
// FIN   | done pulse; results valid; a new start may be accepted
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_b_zero;

  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_sel;
  logic             w_ge;
  logic [WIDTH-1:0] w_p_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_last;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_b_zero = (b == '0);
  assign w_last   = (r_cnt == CW'(1));

  // Restoring step: shift the next dividend bit into the partial remainder,
  // then subtract the divisor if it fits. The trial value is one bit wider
  // than the operands so that the compare cannot overflow.
  assign w_trial = {r_p, r_q[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_d};
  assign w_ge    = (w_trial >= {1'b0, r_d});
  assign w_sel   = w_ge ? w_diff : w_trial;
  assign w_p_nxt = w_sel[WIDTH-1:0];
  assign w_q_nxt = {r_q[WIDTH-2:0], w_ge};

`ifdef SIGNED_DIV_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_a_neg;
  logic w_b_neg;
  logic w_unused;

  // The core divides magnitudes. The signs are fixed up on the way out.
  // The quotient is negated if the operand signs differ.
  // The remainder takes the sign of the dividend.
  assign w_a_neg   = sgn & a[WIDTH-1];
  assign w_b_neg   = sgn & b[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -a : a;
  assign w_b_mag   = w_b_neg ? -b : b;
  assign w_quo_fix = r_neg_q ? -w_q_nxt : w_q_nxt;
  assign w_rem_fix = r_neg_r ? -w_p_nxt : w_p_nxt;
  // The top bit of the selected trial value is always zero after a step,
  // so it is not used.
  assign w_unused  = w_sel[WIDTH];

  // Latch the sign-fixup flags when an operation with a nonzero divisor is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept && !w_b_zero) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  logic [1:0] w_unused;

  assign w_a_mag   = a;
  assign w_b_mag   = b;
  assign w_quo_fix = w_q_nxt;
  assign w_rem_fix = w_p_nxt;
  // In this build sgn has no function.
  // The top trial bit is always zero after a step, so it is not used either.
  assign w_unused  = {sgn, w_sel[WIDTH]};
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and the busy/done decode.
  // A start request is honoured only in IDLE or FIN.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE, S_FIN: begin
        done = (r_state == S_FIN);
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_b_zero ? S_FIN : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_FIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, then iterate.
  // The result registers change only when the FSM enters FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p   <= '0;
      r_q   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dz  <= 1'b0;
    end else if (w_accept) begin
      if (w_b_zero) begin
        r_quo <= '1;
        r_rem <= a;
        r_dz  <= 1'b1;
        r_cnt <= '0;
      end else begin
        r_p   <= '0;
        r_q   <= w_a_mag;
        r_d   <= w_b_mag;
        r_cnt <= CW'(WIDTH);
      end
    end else if (r_state == S_RUN) begin
      r_p   <= w_p_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_quo <= w_quo_fix;
        r_rem <= w_rem_fix;
        r_dz  <= 1'b0;
      end
    end
  end

  assign quo = r_quo;
  assign rem = r_rem;
  assign dz  = r_dz;

endmodule
